// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the multicycle RV32I core (shared ALU, unified memory).
// Optional MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until mem_ready is high.
module multicycle_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ALUControl,
  output logic [1:0]            ImmSrc,
  output logic                  RegWrite,
  output logic                  instr_done,
  output logic                  illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL
  } state_t;

  state_t      state, next_state;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  aluop;
  logic        pcupdate, branch;
  logic        irwrite_s, memwrite_s, regwrite_s, done_s, illegal_s;
  logic [1:0]  immsrc_s;
  logic        unused;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

`ifdef MEM_WAIT_EN
  assign unused = ^{instr[31], instr[29:15], instr[11:7]};
`else
  assign unused = ^{instr[31], instr[29:15], instr[11:7], mem_ready};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    aluop      = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        irwrite_s  = 1'b1;
        pcupdate   = 1'b1;
        next_state = DECODE;
`ifdef MEM_WAIT_EN
        if (!mem_ready) begin
          irwrite_s  = 1'b0;
          pcupdate   = 1'b0;
          next_state = FETCH;
        end
`endif
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default: begin
            illegal_s  = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = MEMWB;
`ifdef MEM_WAIT_EN
        if (!mem_ready) next_state = MEMREAD;
`endif
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
        done_s     = 1'b1;
`ifdef MEM_WAIT_EN
        if (!mem_ready) begin
          done_s     = 1'b0;
          next_state = MEMWRITE;
        end
`endif
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        aluop      = 2'b10;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        aluop      = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
        done_s  = 1'b1;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pcupdate   = 1'b1;
        next_state = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

  // funct3 decode only applies to R/I execution; bit 30 selects sub for R-type only
  always_comb begin
    ALUControl = 3'b000;
    case (aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (opcode[5] & instr[30]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    immsrc_s = 2'b00;
    case (opcode)
      OP_SW:   immsrc_s = 2'b01;
      OP_BEQ:  immsrc_s = 2'b10;
      OP_JAL:  immsrc_s = 2'b11;
      default: immsrc_s = 2'b00;
    endcase
  end

  // Enables are gated by rst_n so the reset-time FETCH state cannot write anything
  assign PCWrite    = rst_n & (pcupdate | (branch & zero));
  assign IRWrite    = rst_n & irwrite_s;
  assign MemWrite   = rst_n & memwrite_s;
  assign RegWrite   = rst_n & regwrite_s;
  assign instr_done = rst_n & done_s;
  assign illegal    = rst_n & illegal_s;
  assign ImmSrc     = rst_n ? immsrc_s : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each stimulus cycle queues its expected control vector; a negedge monitor compares.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adrsrc;
    logic       memw;
    logic       irw;
    logic [1:0] resultsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] aluctl;
    logic [1:0] immsrc;
    logic       regw;
    logic       done;
    logic       ill;
  } outs_t;

  typedef enum {
    T_RST, T_FETCH, T_FETCHWAIT, T_DECODE, T_DECODEILL, T_MEMADR, T_MEMREAD,
    T_MEMWB, T_MEMWRITE, T_MEMWRITEWAIT, T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL
  } tstate_t;

  localparam logic [31:0] LW   = 32'h00512183;
  localparam logic [31:0] SW   = 32'h0020A423;
  localparam logic [31:0] SUB  = 32'h40208033;
  localparam logic [31:0] OR   = 32'h0020E033;
  localparam logic [31:0] AND  = 32'h0020F033;
  localparam logic [31:0] SLT  = 32'h0020A033;
  localparam logic [31:0] ADDI = 32'h40008093;
  localparam logic [31:0] BEQI = 32'h00208463;
  localparam logic [31:0] JALI = 32'h008000EF;
  localparam logic [31:0] ILL  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;

  outs_t expQ[$];
  string tagQ[$];
  int    checks = 0;
  int    errors = 0;
  logic  idleRdy;

  multicycle_controller #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Expected control vector for one cycle, straight from the state table
  function automatic outs_t expFor(tstate_t st, logic z, logic [2:0] alu, logic [1:0] imm);
    outs_t e;
    e = '0;
    e.immsrc = imm;
    case (st)
      T_RST:          begin e.srcb = 2'b10; e.resultsrc = 2'b10; e.immsrc = 2'b00; end
      T_FETCH:        begin e.pcw = 1; e.irw = 1; e.srcb = 2'b10; e.resultsrc = 2'b10; end
      T_FETCHWAIT:    begin e.srcb = 2'b10; e.resultsrc = 2'b10; end
      T_DECODE:       begin e.srca = 2'b01; e.srcb = 2'b01; end
      T_DECODEILL:    begin e.srca = 2'b01; e.srcb = 2'b01; e.ill = 1; end
      T_MEMADR:       begin e.srca = 2'b10; e.srcb = 2'b01; end
      T_MEMREAD:      e.adrsrc = 1;
      T_MEMWB:        begin e.resultsrc = 2'b01; e.regw = 1; e.done = 1; end
      T_MEMWRITE:     begin e.adrsrc = 1; e.memw = 1; e.done = 1; end
      T_MEMWRITEWAIT: begin e.adrsrc = 1; e.memw = 1; end
      T_EXECR:        begin e.srca = 2'b10; e.srcb = 2'b00; e.aluctl = alu; end
      T_EXECI:        begin e.srca = 2'b10; e.srcb = 2'b01; e.aluctl = alu; end
      T_ALUWB:        begin e.regw = 1; e.done = 1; end
      T_BEQ:          begin e.srca = 2'b10; e.aluctl = 3'b001; e.done = 1; e.pcw = z; end
      T_JAL:          begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      default:        e = '0;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input string tag, input logic r, input logic [31:0] i,
                               input logic z, input logic rdy, input tstate_t st,
                               input logic [2:0] alu, input logic [1:0] imm);
    @(posedge clk);
    #1;
    rst_n     = r;
    instr     = i;
    zero      = z;
    mem_ready = rdy;
    expQ.push_back(expFor(st, z, alu, imm));
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput(input string tag, input outs_t e);
    outs_t a;
    a = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
          ALUControl, ImmSrc, RegWrite, instr_done, illegal};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (pcw adr memw irw res srcA srcB alu imm regw done ill)",
               tag, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) checkOutput(tagQ.pop_front(), expQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef MEM_WAIT_EN
    idleRdy = 1'b1;
`else
    idleRdy = 1'b0;
`endif
    rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b1;

    for (int k = 0; k < 3; k++) applyStimulus("reset", 0, 32'h0, 0, 1, T_RST, 3'b000, 2'b00);

    applyStimulus("lw fetch",   1, LW, 0, 1,       T_FETCH,   3'b000, 2'b00);
    applyStimulus("lw decode",  1, LW, 0, 1,       T_DECODE,  3'b000, 2'b00);
    applyStimulus("lw memadr",  1, LW, 0, 1,       T_MEMADR,  3'b000, 2'b00);
    applyStimulus("lw memread", 1, LW, 0, idleRdy, T_MEMREAD, 3'b000, 2'b00);
    applyStimulus("lw memwb",   1, LW, 0, 1,       T_MEMWB,   3'b000, 2'b00);

    applyStimulus("sub fetch",  1, SUB, 0, 1, T_FETCH,  3'b000, 2'b00);
    applyStimulus("sub decode", 1, SUB, 0, 1, T_DECODE, 3'b000, 2'b00);
    applyStimulus("sub execr",  1, SUB, 0, 1, T_EXECR,  3'b001, 2'b00);
    applyStimulus("sub aluwb",  1, SUB, 0, 1, T_ALUWB,  3'b000, 2'b00);

    applyStimulus("or fetch",   1, OR,  0, 1, T_FETCH,  3'b000, 2'b00);
    applyStimulus("or decode",  1, OR,  0, 1, T_DECODE, 3'b000, 2'b00);
    applyStimulus("or execr",   1, OR,  0, 1, T_EXECR,  3'b011, 2'b00);
    applyStimulus("or aluwb",   1, OR,  0, 1, T_ALUWB,  3'b000, 2'b00);

    applyStimulus("and fetch",  1, AND, 0, 1, T_FETCH,  3'b000, 2'b00);
    applyStimulus("and decode", 1, AND, 0, 1, T_DECODE, 3'b000, 2'b00);
    applyStimulus("and execr",  1, AND, 0, 1, T_EXECR,  3'b010, 2'b00);
    applyStimulus("and aluwb",  1, AND, 0, 1, T_ALUWB,  3'b000, 2'b00);

    applyStimulus("slt fetch",  1, SLT, 0, 1, T_FETCH,  3'b000, 2'b00);
    applyStimulus("slt decode", 1, SLT, 0, 1, T_DECODE, 3'b000, 2'b00);
    applyStimulus("slt execr",  1, SLT, 0, 1, T_EXECR,  3'b101, 2'b00);
    applyStimulus("slt aluwb",  1, SLT, 0, 1, T_ALUWB,  3'b000, 2'b00);

    applyStimulus("addi fetch",  1, ADDI, 0, 1, T_FETCH,  3'b000, 2'b00);
    applyStimulus("addi decode", 1, ADDI, 0, 1, T_DECODE, 3'b000, 2'b00);
    applyStimulus("addi execi",  1, ADDI, 0, 1, T_EXECI,  3'b000, 2'b00);
    applyStimulus("addi aluwb",  1, ADDI, 0, 1, T_ALUWB,  3'b000, 2'b00);

    applyStimulus("beq1 fetch",  1, BEQI, 1, 1, T_FETCH,  3'b000, 2'b10);
    applyStimulus("beq1 decode", 1, BEQI, 1, 1, T_DECODE, 3'b000, 2'b10);
    applyStimulus("beq1 beq",    1, BEQI, 1, 1, T_BEQ,    3'b001, 2'b10);
    applyStimulus("beq0 fetch",  1, BEQI, 0, 1, T_FETCH,  3'b000, 2'b10);
    applyStimulus("beq0 decode", 1, BEQI, 0, 1, T_DECODE, 3'b000, 2'b10);
    applyStimulus("beq0 beq",    1, BEQI, 0, 1, T_BEQ,    3'b001, 2'b10);

    applyStimulus("jal fetch",  1, JALI, 0, 1, T_FETCH,  3'b000, 2'b11);
    applyStimulus("jal decode", 1, JALI, 0, 1, T_DECODE, 3'b000, 2'b11);
    applyStimulus("jal jal",    1, JALI, 0, 1, T_JAL,    3'b000, 2'b11);
    applyStimulus("jal aluwb",  1, JALI, 0, 1, T_ALUWB,  3'b000, 2'b11);

    applyStimulus("ill fetch",  1, ILL, 0, 1, T_FETCH,     3'b000, 2'b00);
    applyStimulus("ill decode", 1, ILL, 0, 1, T_DECODEILL, 3'b000, 2'b00);

    applyStimulus("swabort fetch",  1, SW, 0, 1, T_FETCH,  3'b000, 2'b01);
    applyStimulus("swabort decode", 1, SW, 0, 1, T_DECODE, 3'b000, 2'b01);
    applyStimulus("swabort memadr", 1, SW, 0, 1, T_MEMADR, 3'b000, 2'b01);
    applyStimulus("swabort reset",  0, SW, 0, 1, T_RST,    3'b000, 2'b00);

    applyStimulus("sw fetch",    1, SW, 0, idleRdy, T_FETCH,    3'b000, 2'b01);
    applyStimulus("sw decode",   1, SW, 0, 1,       T_DECODE,   3'b000, 2'b01);
    applyStimulus("sw memadr",   1, SW, 0, 1,       T_MEMADR,   3'b000, 2'b01);
    applyStimulus("sw memwrite", 1, SW, 0, 1,       T_MEMWRITE, 3'b000, 2'b01);

`ifdef MEM_WAIT_EN
    applyStimulus("wait fetch stall", 1, SW, 0, 0, T_FETCHWAIT,    3'b000, 2'b01);
    applyStimulus("wait fetch go",    1, SW, 0, 1, T_FETCH,        3'b000, 2'b01);
    applyStimulus("wait decode",      1, SW, 0, 1, T_DECODE,       3'b000, 2'b01);
    applyStimulus("wait memadr",      1, SW, 0, 1, T_MEMADR,       3'b000, 2'b01);
    applyStimulus("wait memwrite 1",  1, SW, 0, 0, T_MEMWRITEWAIT, 3'b000, 2'b01);
    applyStimulus("wait memwrite 2",  1, SW, 0, 0, T_MEMWRITEWAIT, 3'b000, 2'b01);
    applyStimulus("wait memwrite 3",  1, SW, 0, 1, T_MEMWRITE,     3'b000, 2'b01);
`endif

    applyStimulus("final fetch", 1, LW, 0, 1, T_FETCH, 3'b000, 2'b00);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
